detect_window_counter: RTL and testbench
========================================

# detect_window_counter

Downstream consumer of the sequence detector's one-cycle match pulse. It counts match pulses over fixed back-to-back windows of `WINDOW` cycles and presents each window's count through a one-deep valid/ready output register. Counts saturate, with an overflow flag. A result that cannot be delivered is dropped and flagged.

## Interface
Parameters:
- `WINDOW`, default 16: window length in clock cycles; legal range ≥ 2.
- `CNT_W`, default 4: width of the count; legal range ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-low (0 = reset); released synchronously to `clk` upstream.
- `en`  in  1: window counting enable.
- `q_in`  in  1: match pulse from the detector; every high cycle counts as one event.
- `ready`  in  1: downstream accepts the result this cycle.
- `valid`  out  1: `count_out`/`overflow` hold an undelivered result.
- `count_out`  out  CNT_W: event count for the reported window.
- `overflow`  out  1: count saturated during the reported window.
- `lost`  out  1: sticky; at least one window result was dropped.

## Operation
- Timer width is $clog2(WINDOW).
- FSM states:
  - IDLE: timer = 0, accumulator = 0. Go to COUNT in the cycle after `en` = 1 is sampled.
  - COUNT: while `en` = 1, the timer increments every cycle. A sampled `q_in` = 1 adds 1 to the accumulator.
  - COUNT with `en` = 0 sampled: go to IDLE. The partial window is discarded and the output register is untouched.
- Saturation:
  - The accumulator saturates at 2^CNT_W − 1.
  - An increment attempted at that maximum sets the window's overflow bit. The accumulator does not wrap.
- Window end is the cycle with timer == WINDOW−1 in COUNT:
  - The final value is the accumulator plus that cycle's `q_in`, saturated.
  - The timer wraps to 0 and the accumulator clears to 0. The next window starts on the next cycle with no gap.
- Output register, one entry:
  - Loaded at window end if `valid` = 0, or if `valid` & `ready` in that same cycle (transfer plus reload, `valid` stays 1).
  - Otherwise the new result is dropped and `lost` ← 1. The held result is not overwritten.
- Handshake:
  - Transfer occurs when `valid` & `ready`.
  - While `valid` = 1 and no transfer, `count_out` and `overflow` are stable.
  - `valid` falls the cycle after a transfer unless a reload happened in the same cycle.
- `en` deassertion does not clear a pending `valid`. The pending result still completes its handshake.

## Timing
- Reset values: state = IDLE, timer = 0, accumulator = 0, `valid` = 0, `count_out` = 0, `overflow` = 0, `lost` = 0.
- Reset asserted mid-window or with a result pending: everything returns to reset values. The pending result is discarded and `lost` is cleared.
- `lost` clears only on reset.
- Latency: the result is visible with `valid` = 1 one cycle after the window-end cycle.
- With `en` held from cycle 0, the first window covers the WINDOW cycles starting at cycle 1 (the IDLE→COUNT transition cycle). `valid` rises at cycle WINDOW+1.
- `q_in` sampled in IDLE, or in the cycle `en` is first seen, is not counted.
- Throughput: one result per WINDOW cycles.
- All outputs are registered. There is no combinational path from `ready`, `en` or `q_in` to any output.

## Structure
- Shared package `detect_pkg`: state typedef `dwc_state_t` {IDLE, COUNT}, 1-bit encoding. The detector's state typedef lives in the same package.
- One sub-module: `window_timer`.
  - Parameter: WINDOW.
  - Inputs: `clk`, `reset`, `run`.
  - Outputs: `last` (timer == WINDOW−1) and the timer value.
  - Clears to 0 when `run` = 0.
- Accumulator, output register and FSM stay in the top module.

## Test plan
All scenarios use WINDOW = 8, CNT_W = 3.

1. Hold `en` = 1 and `ready` = 0, pulse `q_in` on window cycles 1, 3, 5 -> `valid` = 1 one cycle after the window end, `count_out` = 3, `overflow` = 0. Then `ready` = 1 for one cycle -> `valid` = 0 next cycle.
2. Hold `q_in` = 1 for an entire window -> `count_out` = 7, `overflow` = 1. The next window with no pulses reports `count_out` = 0, `overflow` = 0.
3. Hold `ready` = 0 across two window ends (counts 2, then 4) -> `count_out` stays 2, `lost` = 1 from the cycle after the second window end.
4. `valid` = 1 pending and `ready` = 1 exactly in a window-end cycle (new count 5) -> `valid` stays 1, `count_out` = 5 next cycle, `lost` = 0.
5. Drop `en` at window cycle 4 after 2 pulses -> IDLE, no new `valid`. Re-raise `en` -> the next result counts only pulses in the fresh window.
6. Assert `reset` = 0 mid-window with `valid` = 1 and `lost` = 1 -> all outputs 0 immediately (asynchronous). After release, the first result appears only after a full new window.

Source files
------------

// File: rtl/detect_pkg.sv
// Shared types for the sequence detector and its downstream window counter.
package detect_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dwc_state_t;

  typedef enum logic [1:0] {
    DET_S0,
    DET_S1,
    DET_S2,
    DET_S3
  } det_state_t;

endpackage

// File: rtl/detect_window_counter_if.sv
// Result handshake between the window counter and its consumer.
// valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
// while valid is 1 and no transfer happens, count_out and overflow hold steady.
interface detect_window_counter_if #(
  parameter int CNT_W = 4
);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] count_out;
  logic             overflow;

  modport master (output valid, output count_out, output overflow, input ready);
  modport slave  (input valid, input count_out, input overflow, output ready);
endinterface

// File: rtl/detect_window_counter_window_timer.sv
// Free-running window timer: counts 0..WINDOW-1 while run is high, flags the last cycle.
module window_timer #(
  parameter int WINDOW = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  output logic                      last,
  output logic [$clog2(WINDOW)-1:0] timer
);

  localparam int TW = $clog2(WINDOW);

  logic [TW-1:0] timer_q;

  assign last  = (timer_q == TW'(WINDOW - 1));
  assign timer = timer_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (!run || last) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: rtl/detect_window_counter.sv
// Counts detector match pulses over back-to-back WINDOW-cycle windows and
// offers each window's saturating count through a one-deep output register.
module detect_window_counter
  import detect_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        q_in,
  detect_window_counter_if.master     bus,
  output logic                        lost,
  output dwc_state_t                  dbg_state,
  output logic [$clog2(WINDOW)-1:0]   dbg_timer
);

  dwc_state_t       state_q, state_d;
  logic             run, last, win_end, load, at_max;
  logic [CNT_W-1:0] acc_q, final_cnt;
  logic             ovf_q, final_ovf;
  logic             valid_q, out_ovf_q, lost_q;
  logic [CNT_W-1:0] out_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = COUNT;
      COUNT:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run     = (state_q == COUNT) && en;
  assign win_end = run && last;

  window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .last  (last),
    .timer (dbg_timer)
  );

  // Value the window would close with if this were its last cycle.
  assign at_max    = (acc_q == '1);
  assign final_cnt = (q_in && !at_max) ? acc_q + CNT_W'(1) : acc_q;
  assign final_ovf = ovf_q || (q_in && at_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (!run || last) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= final_cnt;
      ovf_q <= final_ovf;
    end
  end

  // A window result is accepted if the slot is empty or drains this same cycle.
  assign load = win_end && (!valid_q || bus.ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      if (load) begin
        valid_q   <= 1'b1;
        out_cnt_q <= final_cnt;
        out_ovf_q <= final_ovf;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
      if (win_end && !load) lost_q <= 1'b1;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.count_out = out_cnt_q;
  assign bus.overflow  = out_ovf_q;
  assign lost          = lost_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_detect_window_counter.sv
// Directed bench for detect_window_counter with WINDOW = 8, CNT_W = 3.
module tb_detect_window_counter;
  import detect_pkg::*;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       q_in  = 1'b0;
  logic       lost;
  dwc_state_t dbg_state;
  logic [2:0] dbg_timer;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W:0] exp_q[$];

  detect_window_counter_if #(.CNT_W(CNT_W)) bus ();

  detect_window_counter #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .q_in      (q_in),
    .bus       (bus.master),
    .lost      (lost),
    .dbg_state (dbg_state),
    .dbg_timer (dbg_timer)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard
  task automatic expect_result(input int cnt, input logic ovf);
    exp_q.push_back({ovf, CNT_W'(cnt)});
  endtask

  task automatic check_result(input string tag);
    logic [CNT_W:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    check({tag, "_count"}, 32'(bus.count_out), 32'(e[CNT_W-1:0]));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(e[CNT_W]));
  endtask

  // drivers
  task automatic drive_window(input logic [7:0] qb, input logic [7:0] rb);
    for (int i = 0; i < WINDOW; i++) begin
      q_in      = qb[i];
      bus.ready = rb[i];
      step();
    end
    q_in      = 1'b0;
    bus.ready = 1'b0;
  endtask

  // Return to IDLE (draining any pending result), then start a fresh window.
  task automatic restart();
    en        = 1'b0;
    bus.ready = 1'b1;
    step();
    step();
    bus.ready = 1'b0;
    en        = 1'b1;
    step();
  endtask

  initial begin
    bus.ready = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_count", 32'(bus.count_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_timer", 32'(dbg_timer), 32'd0);
    reset = 1'b1;
    step();

    // 1: three pulses, then a single-cycle handshake
    restart();
    check("s1_pre_valid", 32'(bus.valid), 32'd0);
    expect_result(3, 1'b0);
    drive_window(8'b0010_1010, 8'h00);
    check_result("s1");
    check("s1_lost", 32'(lost), 32'd0);
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    check("s1_drained", 32'(bus.valid), 32'd0);

    // 2: saturation, then an empty window
    restart();
    expect_result(7, 1'b1);
    drive_window(8'hFF, 8'h00);
    check_result("s2_sat");
    expect_result(0, 1'b0);
    drive_window(8'h00, 8'b0000_0001);
    check_result("s2_empty");
    check("s2_lost", 32'(lost), 32'd0);

    // 3: second result dropped while first is held
    restart();
    expect_result(2, 1'b0);
    drive_window(8'b0000_0011, 8'h00);
    check_result("s3_first");
    check("s3_lost_before", 32'(lost), 32'd0);
    expect_result(2, 1'b0);
    drive_window(8'b0000_1111, 8'h00);
    check_result("s3_held");
    check("s3_lost_after", 32'(lost), 32'd1);

    // 4: transfer and reload in the window-end cycle
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("s4_lost_cleared", 32'(lost), 32'd0);
    restart();
    expect_result(3, 1'b0);
    drive_window(8'b0000_0111, 8'h00);
    check_result("s4_first");
    expect_result(5, 1'b0);
    drive_window(8'b0001_1111, 8'b1000_0000);
    check_result("s4_reload");
    check("s4_lost", 32'(lost), 32'd0);

    // 5: en dropped mid-window discards the partial count
    restart();
    for (int i = 0; i < 4; i++) begin
      q_in = (i < 2);
      step();
    end
    en   = 1'b0;
    q_in = 1'b0;
    step();
    check("s5_idle", 32'(dbg_state), 32'(IDLE));
    q_in = 1'b1;
    repeat (10) step();
    q_in = 1'b0;
    check("s5_no_valid", 32'(bus.valid), 32'd0);
    restart();
    expect_result(1, 1'b0);
    drive_window(8'b0001_0000, 8'h00);
    check_result("s5_fresh");

    // 6: asynchronous reset with a pending result and lost set
    expect_result(1, 1'b0);
    drive_window(8'b0000_0001, 8'h00);
    check_result("s6_held");
    check("s6_lost_set", 32'(lost), 32'd1);
    q_in = 1'b1;
    step();
    step();
    q_in = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_valid", 32'(bus.valid), 32'd0);
    check("s6_async_count", 32'(bus.count_out), 32'd0);
    check("s6_async_ovf", 32'(bus.overflow), 32'd0);
    check("s6_async_lost", 32'(lost), 32'd0);
    check("s6_async_state", 32'(dbg_state), 32'(IDLE));
    step();
    q_in  = 1'b1;
    reset = 1'b1;
    step();
    check("s6_count_state", 32'(dbg_state), 32'(COUNT));
    for (int i = 0; i < WINDOW; i++) begin
      q_in = (i < 3);
      step();
      if (i == WINDOW - 2) check("s6_early_valid", 32'(bus.valid), 32'd0);
    end
    q_in = 1'b0;
    expect_result(3, 1'b0);
    check_result("s6_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
